// File: rtl/readout_pkg.sv
// readout_pkg: shared constants for the spectrogram readout sequencer.
//   - FSM state encoding (also visible on state_o for debug)
//   - bank service modes (FULL bank / PART bank at event end)
//   - cnt_width(): bits needed to hold values 0..max_val
package readout_pkg;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_HDR_LOAD   = 3'd1;
    localparam logic [2:0] ST_HDR_SHIFT  = 3'd2;
    localparam logic [2:0] ST_WORD_LOAD  = 3'd3;
    localparam logic [2:0] ST_WORD_SHIFT = 3'd4;
    localparam logic [2:0] ST_WAIT       = 3'd5;

    localparam logic MODE_FULL = 1'b0;
    localparam logic MODE_PART = 1'b1;

    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/readout_pending_tracker.sv
// readout_pending_tracker: records events from the memorisation block until
// the sequencer starts serving them.
//   clk, reset_n        clock, async active-low reset
//   bank_full[NBANK]    pulse per completely filled bank
//   mem_done, idx_final event end; last written address of the partial bank
//   pop_full, pop_part  sequencer consumed one full / the partial bank
//   pend_full           number of full banks waiting (0..NBANK)
//   pend_part, part_idx partial bank waiting and its last address
//   overrun             sticky: an event could not be recorded
module readout_pending_tracker
    import readout_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int NBANK  = 2,
    parameter int CNT_W  = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NBANK-1:0]  bank_full,
    input  logic              mem_done,
    input  logic [ADDR_W-1:0] idx_final,
    input  logic              pop_full,
    input  logic              pop_part,
    output logic [CNT_W-1:0]  pend_full,
    output logic              pend_part,
    output logic [ADDR_W-1:0] part_idx,
    output logic              overrun
);

    logic [CNT_W-1:0]  pend_full_q, pend_full_d;
    logic              pend_part_q, pend_part_d;
    logic [ADDR_W-1:0] part_idx_q, part_idx_d;
    logic              overrun_q, overrun_d;
    logic [CNT_W:0]    inc;
    logic [CNT_W:0]    sum;

    always_comb begin
        inc = '0;
        for (int i = 0; i < NBANK; i++) begin
            inc = inc + (CNT_W+1)'(bank_full[i]);
        end
        // One extra bit so a burst of increments cannot wrap before saturation.
        sum = {1'b0, pend_full_q} + inc - (CNT_W+1)'(pop_full);

        overrun_d   = overrun_q;
        pend_full_d = sum[CNT_W-1:0];
        if (sum > (CNT_W+1)'(NBANK)) begin
            pend_full_d = CNT_W'(NBANK);
            overrun_d   = 1'b1;
        end

        pend_part_d = pend_part_q & ~pop_part;
        part_idx_d  = part_idx_q;
        if (mem_done) begin
            if (pend_part_d) begin
                overrun_d = 1'b1;
            end else begin
                pend_part_d = 1'b1;
                part_idx_d  = idx_final;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_full_q <= '0;
            pend_part_q <= 1'b0;
            part_idx_q  <= '0;
            overrun_q   <= 1'b0;
        end else begin
            pend_full_q <= pend_full_d;
            pend_part_q <= pend_part_d;
            part_idx_q  <= part_idx_d;
            overrun_q   <= overrun_d;
        end
    end

    assign pend_full = pend_full_q;
    assign pend_part = pend_part_q;
    assign part_idx  = part_idx_q;
    assign overrun   = overrun_q;

endmodule

// File: rtl/readout_sequencer.sv
// readout_sequencer: serialises an event header followed by spectrogram words
// read from an NBANK-bank channel memory into the serial shift chain.
//   clk, reset_n      clock, async active-low reset
//   bank_full         pulse per completely filled bank
//   mem_done          event ended; idx_final = last written address
//   shift_en          downstream ready; 0 freezes the sequencer
//   addr_out, re      memory read {rd_bank, idx}, one cycle before WORD_LOAD
//   sl_time, sl_ch    load timestamp / memory word into the shift chain
//   selection_bit     0 = timestamp chain, 1 = channel chain
//   serial_readout    shift active
//   sending_data      frame in progress
//   overrun           sticky event-lost flag
//   state_o           current state
//
// state      | meaning
// IDLE       | nothing pending
// HDR_LOAD   | load timestamp into the chain
// HDR_SHIFT  | shift TS_W header bits
// WORD_LOAD  | load memory word (read issued the cycle before)
// WORD_SHIFT | shift the rest of the word
// WAIT       | full bank done, waiting for next bank or timeout
module readout_sequencer
    import readout_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int DEPTH      = 200,
    parameter int BANK_W     = 1,
    parameter int TS_W       = 31,
    parameter int WORD_SHIFT = 2,
    parameter int WAIT_TO    = 4096
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [2**BANK_W-1:0]     bank_full,
    input  logic                     mem_done,
    input  logic [ADDR_W-1:0]        idx_final,
    input  logic                     shift_en,
    output logic [BANK_W+ADDR_W-1:0] addr_out,
    output logic                     re,
    output logic                     sl_time,
    output logic                     sl_ch,
    output logic                     selection_bit,
    output logic                     serial_readout,
    output logic                     sending_data,
    output logic                     overrun,
    output logic [2:0]               state_o
);

    localparam int NBANK   = 2**BANK_W;
    localparam int PF_W    = cnt_width(NBANK);
    localparam int CNT_MAX = (TS_W > WAIT_TO) ? ((TS_W > WORD_SHIFT) ? TS_W : WORD_SHIFT)
                                              : ((WAIT_TO > WORD_SHIFT) ? WAIT_TO : WORD_SHIFT);
    localparam int TW      = cnt_width(CNT_MAX);

    logic [2:0]        state_q, state_d;
    logic [TW-1:0]     cnt_q, cnt_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [BANK_W-1:0] rd_bank_q, rd_bank_d;
    logic              mode_q, mode_d;
    logic              last_q, last_d;
    logic [ADDR_W-1:0] last_idx_q, last_idx_d;

    logic [PF_W-1:0]   pend_full;
    logic              pend_part;
    logic [ADDR_W-1:0] part_idx;
    logic              pop_full, pop_part;
    logic              pend_any, full_avail, bank_start, go_load;
    logic [ADDR_W-1:0] start_last, cmp_last;

    readout_pending_tracker #(
        .ADDR_W (ADDR_W),
        .NBANK  (NBANK),
        .CNT_W  (PF_W)
    ) u_tracker (
        .clk       (clk),
        .reset_n   (reset_n),
        .bank_full (bank_full),
        .mem_done  (mem_done),
        .idx_final (idx_final),
        .pop_full  (pop_full),
        .pop_part  (pop_part),
        .pend_full (pend_full),
        .pend_part (pend_part),
        .part_idx  (part_idx),
        .overrun   (overrun)
    );

    always_comb begin
        full_avail = (pend_full != '0);
        pend_any   = full_avail | pend_part;
        bank_start = ((state_q == ST_HDR_SHIFT) && (cnt_q == '0)) ||
                     ((state_q == ST_WAIT) && pend_any);
        go_load    = bank_start ||
                     ((state_q == ST_WORD_SHIFT) && (cnt_q == '0) && !last_q);
        // part_idx is latched at bank start so a new mem_done arriving while
        // this bank is served cannot move its end point.
        start_last = full_avail ? ADDR_W'(DEPTH - 1) : part_idx;
        cmp_last   = bank_start ? start_last : last_idx_q;

        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        rd_bank_d  = rd_bank_q;
        mode_d     = mode_q;
        last_d     = last_q;
        last_idx_d = last_idx_q;
        pop_full   = 1'b0;
        pop_part   = 1'b0;

        if (shift_en) begin
            if (go_load) begin
                idx_d  = idx_q + ADDR_W'(1);
                last_d = (idx_q == cmp_last);
            end
            if (bank_start) begin
                mode_d     = full_avail ? MODE_FULL : MODE_PART;
                last_idx_d = start_last;
                pop_full   = full_avail;
                pop_part   = !full_avail;
            end
            case (state_q)
                ST_IDLE: begin
                    if (pend_any) state_d = ST_HDR_LOAD;
                end
                ST_HDR_LOAD: begin
                    state_d = ST_HDR_SHIFT;
                    cnt_d   = TW'(TS_W - 1);
                end
                ST_HDR_SHIFT: begin
                    if (cnt_q == '0) state_d = ST_WORD_LOAD;
                    else             cnt_d   = cnt_q - TW'(1);
                end
                ST_WORD_LOAD: begin
                    state_d = ST_WORD_SHIFT;
                    cnt_d   = TW'(WORD_SHIFT - 2);
                end
                ST_WORD_SHIFT: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - TW'(1);
                    end else if (!last_q) begin
                        state_d = ST_WORD_LOAD;
                    end else begin
                        // Clearing idx here means addr_out already shows
                        // address 0 in the cycle the next bank starts.
                        rd_bank_d = rd_bank_q + BANK_W'(1);
                        idx_d     = '0;
                        if (mode_q == MODE_FULL) begin
                            state_d = ST_WAIT;
                            cnt_d   = (WAIT_TO > 0) ? TW'(WAIT_TO - 1) : '0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_WAIT: begin
                    if (pend_any)                         state_d = ST_WORD_LOAD;
                    else if ((WAIT_TO > 0) && (cnt_q == '0)) state_d = ST_IDLE;
                    else if (cnt_q != '0)                 cnt_d   = cnt_q - TW'(1);
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            rd_bank_q  <= '0;
            mode_q     <= MODE_FULL;
            last_q     <= 1'b0;
            last_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            rd_bank_q  <= rd_bank_d;
            mode_q     <= mode_d;
            last_q     <= last_d;
            last_idx_q <= last_idx_d;
        end
    end

    // re follows go_load regardless of shift_en so it holds during a stall.
    assign re             = go_load;
    assign addr_out       = {rd_bank_q, idx_q};
    assign sl_time        = (state_q == ST_HDR_LOAD);
    assign sl_ch          = (state_q == ST_WORD_LOAD);
    assign selection_bit  = (state_q == ST_WORD_LOAD) || (state_q == ST_WORD_SHIFT) ||
                            (state_q == ST_WAIT);
    assign serial_readout = (state_q == ST_HDR_SHIFT) || selection_bit;
    assign sending_data   = (state_q == ST_HDR_LOAD) || (state_q == ST_HDR_SHIFT) ||
                            (state_q == ST_WORD_LOAD) || (state_q == ST_WORD_SHIFT);
    assign state_o        = state_q;

endmodule

// File: tb/tb_readout_sequencer.sv
module tb_readout_sequencer;

    localparam int ADDR_W     = 8;
    localparam int DEPTH      = 200;
    localparam int BANK_W     = 1;
    localparam int NB         = 2;
    localparam int TS_W       = 31;
    localparam int WORD_SHIFT = 2;
    localparam int WAIT_TO    = 16;
    localparam int HDR_TOK    = -1;

    logic                     clk = 1'b0;
    logic                     reset_n = 1'b1;
    logic [NB-1:0]            bank_full = '0;
    logic                     mem_done = 1'b0;
    logic [ADDR_W-1:0]        idx_final = '0;
    logic                     shift_en = 1'b1;
    logic [BANK_W+ADDR_W-1:0] addr_out;
    logic                     re, sl_time, sl_ch, selection_bit;
    logic                     serial_readout, sending_data, overrun;
    logic [2:0]               state_o;

    readout_sequencer #(
        .ADDR_W(ADDR_W), .DEPTH(DEPTH), .BANK_W(BANK_W),
        .TS_W(TS_W), .WORD_SHIFT(WORD_SHIFT), .WAIT_TO(WAIT_TO)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bank_full(bank_full), .mem_done(mem_done),
        .idx_final(idx_final), .shift_en(shift_en), .addr_out(addr_out), .re(re),
        .sl_time(sl_time), .sl_ch(sl_ch), .selection_bit(selection_bit),
        .serial_readout(serial_readout), .sending_data(sending_data),
        .overrun(overrun), .state_o(state_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_mis = 0;
    int exp_q[$];
    int model_bank = 0;
    int model_overrun = 0;
    int stall_pct = 0;
    logic force_stall = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame is a header token followed by whole banks in
    // arrival order; each bank lives in the next bank slot mod NB.
    task automatic push_hdr();
        exp_q.push_back(HDR_TOK);
    endtask

    task automatic push_bank(input int last);
        for (int a = 0; a <= last; a++) exp_q.push_back(model_bank * (1 << ADDR_W) + a);
        model_bank = (model_bank + 1) % NB;
    endtask

    task automatic pulse(input logic [NB-1:0] bf, input logic md, input int idx);
        @(posedge clk); #1;
        bank_full = bf; mem_done = md; idx_final = ADDR_W'(idx);
        @(posedge clk); #1;
        bank_full = '0; mem_done = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] st, input int bound);
        int k;
        for (k = 0; k < bound; k++) begin
            @(negedge clk);
            if (state_o == st) break;
        end
        if (k == bound) begin
            n_vec++; n_mis++;
            $display("FAIL wait_state: state %0d never reached, got %0d", st, state_o);
        end
    endtask

    task automatic wait_idle(input string name);
        int k;
        for (k = 0; k < 20000; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && state_o == 3'd0) break;
        end
        if (k == 20000) begin
            n_vec++; n_mis++;
            $display("FAIL %s_timeout: %0d tokens outstanding, state %0d", name, exp_q.size(), state_o);
            exp_q.delete();
        end
        repeat (5) @(negedge clk);
        check({name, "_bank_ptr"}, int'(addr_out), model_bank * (1 << ADDR_W));
        check({name, "_overrun"}, int'(overrun), model_overrun);
    endtask

    // shift_en driver
    initial forever begin
        @(posedge clk); #1;
        shift_en = force_stall ? 1'b0 : ($urandom_range(0, 99) >= stall_pct);
    end

    // Monitor: observes only cycles where the sequencer advances.
    initial begin
        int hdr_cnt = 0, gap = 0, wait_cnt = 0, prev_addr = 0;
        logic prev_re = 1'b0, in_run = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                hdr_cnt = 0; gap = 0; wait_cnt = 0; prev_re = 1'b0; in_run = 1'b0;
            end else if (shift_en) begin
                if (sl_time) begin
                    check("header_token", HDR_TOK, exp_q.size() ? exp_q.pop_front() : -99);
                    hdr_cnt = 0;
                end
                if (serial_readout && !selection_bit) hdr_cnt++;
                gap++;
                if (prev_re || sl_ch) check("re_precedes_load", int'(prev_re), int'(sl_ch));
                if (sl_ch) begin
                    if (hdr_cnt != 0) begin
                        check("header_len", hdr_cnt, TS_W);
                        hdr_cnt = 0;
                    end
                    if (in_run) check("word_gap", gap, WORD_SHIFT);
                    check("word_addr", prev_addr, exp_q.size() ? exp_q.pop_front() : -99);
                    gap = 0; in_run = 1'b1; wait_cnt = 0;
                end
                if (serial_readout && !sending_data) begin
                    wait_cnt++; in_run = 1'b0;
                end
                if (!serial_readout) begin
                    if (wait_cnt != 0) check("wait_timeout_len", wait_cnt, WAIT_TO);
                    wait_cnt = 0; in_run = 1'b0;
                end
                prev_re = re;
                if (re) prev_addr = int'(addr_out);
            end
        end
    end

    function automatic int all_outs();
        return int'({addr_out, re, sl_time, sl_ch, selection_bit, serial_readout,
                     sending_data, overrun, state_o});
    endfunction

    initial begin
        int r;
        #2 reset_n = 1'b0;
        #1 check("reset_outputs", all_outs(), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        // short event, idx 9
        push_hdr(); push_bank(9);
        pulse('0, 1'b1, 9);
        wait_idle("short9");

        // random short event with forced 7-cycle stall mid-header
        stall_pct = 20;
        r = $urandom_range(1, DEPTH - 1);
        push_hdr(); push_bank(r);
        pulse('0, 1'b1, r);
        wait_state(3'd2, 200);
        repeat (10) @(posedge clk);
        force_stall = 1'b1;
        repeat (7) @(posedge clk);
        force_stall = 1'b0;
        wait_idle("stall_hdr");

        // part_idx = 0 sends one word
        stall_pct = 0;
        push_hdr(); push_bank(0);
        pulse('0, 1'b1, 0);
        wait_idle("part_zero");

        // long event: two full banks then a partial
        stall_pct = 25;
        push_hdr(); push_bank(DEPTH - 1); push_bank(DEPTH - 1); push_bank(4);
        pulse(NB'(1 << model_bank), 1'b0, 0);
        repeat (150) @(posedge clk);
        pulse(NB'(1 << ((model_bank + NB - 1) % NB)), 1'b0, 0);
        repeat (10) @(posedge clk);
        pulse('0, 1'b1, 4);
        wait_idle("long");

        // full bank, no further event: WAIT timeout
        stall_pct = 10;
        push_hdr(); push_bank(DEPTH - 1);
        pulse(NB'(1 << ((model_bank + NB - 1) % NB)), 1'b0, 0);
        wait_idle("timeout");

        // bank_full and mem_done in the same cycle: full bank first
        stall_pct = 15;
        r = $urandom_range(0, DEPTH - 1);
        push_hdr(); push_bank(DEPTH - 1); push_bank(r);
        pulse(NB'(1 << ((model_bank + NB - 2) % NB)), 1'b1, r);
        wait_idle("simult");

        // randomized mix
        for (int it = 0; it < 4; it++) begin
            stall_pct = $urandom_range(0, 40);
            r = $urandom_range(0, DEPTH - 1);
            push_hdr();
            if ($urandom_range(0, 1) == 0) begin
                push_bank(r);
                pulse('0, 1'b1, r);
            end else begin
                push_bank(DEPTH - 1);
                pulse(NB'(1 << ((model_bank + NB - 1) % NB)), 1'b0, 0);
            end
            wait_idle("random");
        end

        // partial overrun: second idx_final dropped
        stall_pct = 10;
        r = $urandom_range(0, 60);
        push_hdr(); push_bank(r);
        pulse('0, 1'b1, r);
        pulse('0, 1'b1, r + 77);
        model_overrun = 1;
        wait_idle("part_overrun");

        // async reset mid-WORD_SHIFT
        stall_pct = 0;
        push_hdr(); push_bank(50);
        pulse('0, 1'b1, 50);
        wait_state(3'd4, 200);
        repeat (6) @(negedge clk);
        wait_state(3'd4, 10);
        #2 reset_n = 1'b0;
        #1 check("async_reset_outputs", all_outs(), 0);
        exp_q.delete();
        model_bank = 0;
        model_overrun = 0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (40) @(negedge clk);
        check("idle_after_reset", int'(state_o), 0);
        check("overrun_after_reset", int'(overrun), 0);

        // full-bank overrun: third bank_full while two are pending
        stall_pct = 10;
        push_hdr(); push_bank(DEPTH - 1); push_bank(DEPTH - 1);
        pulse(2'b01, 1'b0, 0);
        pulse(2'b10, 1'b0, 0);
        pulse(2'b01, 1'b0, 0);
        model_overrun = 1;
        wait_idle("full_overrun");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
